// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with a STOP/RUN FSM, a run-time prescaler tick,
// single-step in STOP, clamped synchronous preset and a wrap pulse on 99<->00.

module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] digit,
  output logic       carry
);
  // Carry/borrow into the next digit when this one rolls over on an enabled event.
  assign carry = en && (up ? (digit >= 4'd9) : (digit == 4'd0));

  always_ff @(posedge clk) begin
    if (rst)
      digit <= 4'd0;
    else if (load)
      digit <= (load_val > 4'd9) ? 4'd9 : load_val;
    else if (en) begin
      if (up)
        digit <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
      else
        digit <= (digit == 4'd0) ? 4'd9 : ((digit > 4'd9) ? 4'd9 : digit - 4'd1);
    end
  end
endmodule

module bcd_counter_2digit #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_toggle,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       running,
  output logic       wrap
);
  localparam int NUM_DIGITS = 2;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  state_t                             state;
  logic [PW-1:0]                      presc;
  logic                               tick;
  logic                               ev;
  logic [NUM_DIGITS-1:0][3:0]         digits;
  logic [NUM_DIGITS-1:0][3:0]         load_vals;
  logic [NUM_DIGITS-1:0]              en;
  logic [NUM_DIGITS-1:0]              carry;

  assign tick      = (state == RUN) && (presc == LAST);
  assign ev        = tick || ((state == STOP) && step);
  assign load_vals = {load_tens, load_units};

  // Units see the count event; each higher digit is enabled by the carry below it.
  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
        assign en[i] = ev;
      end else begin : g_hsd
        assign en[i] = carry[i-1];
      end
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_vals[i]),
        .en       (en[i]),
        .up       (up),
        .digit    (digits[i]),
        .carry    (carry[i])
      );
    end
  endgenerate

  assign bcd_units = digits[0];
  assign bcd_tens  = digits[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STOP;
      running <= 1'b0;
      presc   <= '0;
      wrap    <= 1'b0;
    end else begin
      // A coinciding tick is still counted by the digits; the toggle only moves the FSM.
      if (run_toggle) begin
        state   <= (state == STOP) ? RUN : STOP;
        running <= (state == STOP);
      end
      if (load || state == STOP || run_toggle || tick)
        presc <= '0;
      else
        presc <= presc + 1'b1;
      wrap <= !load && carry[NUM_DIGITS-1];
    end
  end
endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Table-driven bench for bcd_counter_2digit (TICK_DIV=4) with an expected-value
// queue filled as each cycle's stimulus is driven and drained after the edge.

module tb_bcd_counter_2digit;
  logic       clk = 1'b0;
  logic       rst, run_toggle, step, up, load;
  logic [3:0] load_tens, load_units, bcd_tens, bcd_units;
  logic       running, wrap;

  typedef struct {
    bit         r, rt, st, u, ld;
    logic [3:0] lt, lu, et, eu;
    bit         er, ew;
    string      nm;
  } vec_t;

  typedef struct {
    logic [3:0] t, u;
    bit         r, w;
    string      nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  bcd_counter_2digit #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run_toggle(run_toggle), .step(step), .up(up),
    .load(load), .load_tens(load_tens), .load_units(load_units),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic add(input bit r, rt, st, u, ld, input logic [3:0] lt, lu, et, eu,
                     input bit er, ew, input string nm);
    vec_t v;
    v.r = r; v.rt = rt; v.st = st; v.u = u; v.ld = ld; v.lt = lt; v.lu = lu;
    v.et = et; v.eu = eu; v.er = er; v.ew = ew; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input bit u, input logic [3:0] et, eu,
                      input bit er, input string nm);
    for (int k = 0; k < n; k++) add(0, 0, 0, u, 0, 0, 0, et, eu, er, 0, nm);
  endtask

  task automatic apply(input vec_t v);
    exp_t e, g;
    rst = v.r; run_toggle = v.rt; step = v.st; up = v.u; load = v.ld;
    load_tens = v.lt; load_units = v.lu;
    e.t = v.et; e.u = v.eu; e.r = v.er; e.w = v.ew; e.nm = v.nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    compared++;
    if (bcd_tens !== g.t || bcd_units !== g.u || running !== g.r || wrap !== g.w) begin
      mismatched++;
      $display("FAIL %s: got %0d%0d run=%0b wrap=%0b, want %0d%0d run=%0b wrap=%0b",
               g.nm, bcd_tens, bcd_units, running, wrap, g.t, g.u, g.r, g.w);
    end
  endtask

  initial begin
    rst = 1; run_toggle = 0; step = 0; up = 1; load = 0; load_tens = 0; load_units = 0;

    // reset, also overriding a load
    add(1, 0, 0, 1, 1, 9, 9, 0, 0, 0, 0, "reset_over_load");
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "reset");
    // run and count up every 4 cycles
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "enter_run");
    for (int k = 1; k <= 3; k++) begin
      idle(3, 1, 0, k - 1, 1, "prescale_wait");
      add(0, 0, 0, 1, 0, 0, 0, 0, k, 1, 0, "tick_up");
    end
    // load 98 in RUN, tick to 99 then wrap to 00
    add(0, 0, 0, 1, 1, 9, 8, 9, 8, 1, 0, "load_98");
    idle(3, 1, 9, 8, 1, "wait_98");
    add(0, 0, 0, 1, 0, 0, 0, 9, 9, 1, 0, "tick_99");
    idle(3, 1, 9, 9, 1, "wait_99");
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "wrap_up");
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, "wrap_one_cycle");
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "enter_stop");
    // down step from 00 in STOP, step ignored in RUN
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "load_00");
    add(0, 0, 1, 0, 0, 0, 0, 9, 9, 0, 1, "step_down_wrap");
    add(0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, "wrap_clear");
    add(0, 1, 0, 0, 0, 0, 0, 9, 9, 1, 0, "run_again");
    add(0, 0, 1, 0, 0, 0, 0, 9, 9, 1, 0, "step_in_run");
    add(0, 1, 0, 0, 0, 0, 0, 9, 9, 0, 0, "stop_again");
    // 19 -> 20 up, 20 -> 19 down
    add(0, 0, 0, 1, 1, 1, 9, 1, 9, 0, 0, "load_19");
    add(0, 1, 0, 1, 0, 0, 0, 1, 9, 1, 0, "run_19");
    idle(3, 1, 1, 9, 1, "wait_19");
    add(0, 0, 0, 1, 0, 0, 0, 2, 0, 1, 0, "carry_20");
    idle(3, 0, 2, 0, 1, "wait_20");
    add(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, "borrow_19");
    // clamp, load vs tick, mid-count load clears prescaler
    add(0, 0, 0, 1, 1, 12, 15, 9, 9, 1, 0, "clamp_99");
    idle(3, 1, 9, 9, 1, "wait_clamp");
    add(0, 0, 0, 1, 1, 2, 3, 2, 3, 1, 0, "load_beats_tick");
    idle(2, 1, 2, 3, 1, "wait_23");
    add(0, 0, 0, 1, 1, 4, 5, 4, 5, 1, 0, "load_midcount");
    idle(3, 1, 4, 5, 1, "presc_cleared");
    add(0, 0, 0, 1, 0, 0, 0, 4, 6, 1, 0, "tick_46");
    // toggle coinciding with tick: counted, then STOP
    idle(3, 1, 4, 6, 1, "wait_46");
    add(0, 1, 0, 1, 0, 0, 0, 4, 7, 0, 0, "toggle_with_tick");
    idle(2, 1, 4, 7, 0, "stopped_hold");

    foreach (vecs[i]) apply(vecs[i]);

    // hand sequence: reset during RUN at 57
    begin
      vec_t v;
      v = '{r:0, rt:0, st:0, u:1, ld:1, lt:5, lu:7, et:5, eu:7, er:0, ew:0, nm:"load_57"};
      apply(v);
      v.ld = 0; v.rt = 1; v.er = 1; v.nm = "run_57";
      apply(v);
      v.rt = 0; v.nm = "wait_57";
      apply(v);
      apply(v);
      v.r = 1; v.rt = 1; v.et = 0; v.eu = 0; v.er = 0; v.nm = "reset_in_run";
      apply(v);
      v.r = 0; v.rt = 0; v.nm = "post_reset_idle";
      for (int k = 0; k < 10; k++) apply(v);
      v.rt = 1; v.er = 1; v.nm = "rerun_after_reset";
      apply(v);
      v.rt = 0;
      for (int k = 0; k < 3; k++) apply(v);
      v.eu = 1; v.nm = "first_tick_after_reset";
      apply(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
